dmem_line_responder: RTL

- Responder end of the core's dmem request/response interface (addr, rmask, wmask, wdata, rdata, resp).
- Services word-granular loads and stores from a single-entry, 256-bit write-back line buffer.
- Refills and evicts that line over the 64-bit burst memory (bmem) port.
- Sits between the memory execution unit and the burst memory model, in place of a full dcache.

---
 rtl/rv32i_types.sv | 16 +
 rtl/dmem_line_responder_merge.sv | 24 ++
 rtl/dmem_line_responder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the dmem line responder: FSM state encoding and line/beat widths.
package rv32i_types;

   localparam int BEAT_BITS = 64;
   localparam int LINE_BITS = 256;

   typedef enum logic [2:0] {
      IDLE,
      RESPOND,
      WB,
      FILL_REQ,
      FILL,
      RESPOND_MISS
   } dmem_resp_state_t;

endpackage

// File: rtl/dmem_line_responder_merge.sv
// Combinational byte-lane merge of one 32-bit store word into a cache line.
module line_word_merge
   import rv32i_types::*;
#(
   parameter int LINE_W = LINE_BITS,
   parameter int IDX_W  = 3
) (
   input  logic [LINE_W-1:0] line,
   input  logic [IDX_W-1:0]  word_idx,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wmask,
   output logic [LINE_W-1:0] line_out
);

   always_comb begin
      line_out = line;
      for (int b = 0; b < 4; b++) begin
         if (wmask[b]) begin
            line_out[32*word_idx + 8*b +: 8] = wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/dmem_line_responder.sv
// Single-line write-back buffer answering dmem loads/stores, refilled and evicted over bmem.
//
// state        | meaning
// IDLE         | waiting for a request; hit/miss decided here
// RESPOND      | hit: resp pulse, store merge on this cycle
// WB           | writing the dirty line back, one beat per ready cycle
// FILL_REQ     | holding bmem_read until memory accepts the burst
// FILL         | collecting read beats into the line
// RESPOND_MISS | miss completed: resp pulse, store merge on this cycle
module dmem_line_responder
   import rv32i_types::*;
#(
   parameter int BURST_BEATS = 4,
   parameter int OFFSET_BITS = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] bmem_addr,
   output logic        bmem_read,
   output logic        bmem_write,
   output logic [63:0] bmem_wdata,
   input  logic        bmem_ready,
   input  logic [63:0] bmem_rdata,
   input  logic        bmem_rvalid
);

   localparam int LINE_W = BURST_BEATS * BEAT_BITS;
   localparam int TAG_W  = 32 - OFFSET_BITS;
   localparam int IDX_W  = OFFSET_BITS - 2;
   localparam int CNT_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

   dmem_resp_state_t state, state_next;

   logic [LINE_W-1:0] line;
   logic [LINE_W-1:0] line_merged;
   logic [TAG_W-1:0]  tag;
   logic              line_valid;
   logic              dirty;
   logic [CNT_W-1:0]  cnt;

   logic [31:0]       req_addr;
   logic [3:0]        req_rmask;
   logic [3:0]        req_wmask;
   logic [31:0]       req_wdata;

   logic              req_active;
   logic              hit;
   logic              responding;
   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic              unused_bits;

   assign req_active = |(dmem_rmask | dmem_wmask);
   assign hit        = line_valid && (tag == dmem_addr[31:OFFSET_BITS]);
   assign req_tag    = req_addr[31:OFFSET_BITS];
   assign req_idx    = req_addr[OFFSET_BITS-1:2];
   assign responding = (state == RESPOND) || (state == RESPOND_MISS);

   // Byte offset and rmask are latched for completeness; only wmask steers behaviour.
   assign unused_bits = ^{req_addr[1:0], req_rmask};

   line_word_merge #(
      .LINE_W (LINE_W),
      .IDX_W  (IDX_W)
   ) u_merge (
      .line     (line),
      .word_idx (req_idx),
      .wdata    (req_wdata),
      .wmask    (req_wmask),
      .line_out (line_merged)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_active) begin
               if (hit)        state_next = RESPOND;
               else if (dirty) state_next = WB;
               else            state_next = FILL_REQ;
            end
         end
         RESPOND, RESPOND_MISS: state_next = IDLE;
         WB:       if (bmem_ready && cnt == LAST_BEAT) state_next = FILL_REQ;
         FILL_REQ: if (bmem_ready) state_next = FILL;
         FILL:     if (bmem_rvalid && cnt == LAST_BEAT) state_next = RESPOND_MISS;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line       <= '0;
         tag        <= '0;
         line_valid <= 1'b0;
         dirty      <= 1'b0;
         cnt        <= '0;
         req_addr   <= '0;
         req_rmask  <= '0;
         req_wmask  <= '0;
         req_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_active) begin
                  req_addr  <= dmem_addr;
                  req_rmask <= dmem_rmask;
                  req_wmask <= dmem_wmask;
                  req_wdata <= dmem_wdata;
               end
            end
            RESPOND, RESPOND_MISS: begin
               if (|req_wmask) begin
                  line  <= line_merged;
                  dirty <= 1'b1;
               end
            end
            WB: begin
               if (bmem_ready) begin
                  if (cnt == LAST_BEAT) begin
                     cnt   <= '0;
                     dirty <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            FILL_REQ: begin
               // The line is about to be overwritten beat by beat; it is not usable until complete.
               if (bmem_ready) begin
                  cnt        <= '0;
                  line_valid <= 1'b0;
               end
            end
            FILL: begin
               if (bmem_rvalid) begin
                  line[BEAT_BITS*cnt +: BEAT_BITS] <= bmem_rdata;
                  if (cnt == LAST_BEAT) begin
                     cnt        <= '0;
                     tag        <= req_tag;
                     line_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_resp  = responding;
   assign dmem_rdata = responding ? line[32*req_idx +: 32] : '0;
   assign bmem_read  = (state == FILL_REQ);
   assign bmem_write = (state == WB);
   assign bmem_addr  = (state == WB)       ? {tag,     {OFFSET_BITS{1'b0}}} :
                       (state == FILL_REQ) ? {req_tag, {OFFSET_BITS{1'b0}}} : '0;
   assign bmem_wdata = bmem_write ? line[BEAT_BITS*cnt +: BEAT_BITS] : '0;

endmodule
